// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the two-requester mux arbiter:
//   - arbiter state encoding (IDLE / GNT_A / GNT_B)
//   - side encoding for the "last served" flag
//   - default data width and default maximum hold time
// ---------------------------------------------------------------------------
package mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_A = 2'd1,
      GNT_B = 2'd2
   } arb_state_e;

   localparam logic SIDE_A = 1'b0;
   localparam logic SIDE_B = 1'b1;

   localparam int DEFAULT_WIDTH    = 4;
   localparam int DEFAULT_MAX_HOLD = 4;

   // Width of the hold counter; large enough for MAX_HOLD up to 15.
   localparam int HOLD_W = 4;

endpackage

// File: rtl/mux2t1_4.sv
// ---------------------------------------------------------------------------
// mux2t1_4
// Plain 2-to-1 data multiplexer (combinational).
// Ports:
//   a   in  WIDTH  data selected when sel = 0
//   b   in  WIDTH  data selected when sel = 1
//   sel in  1      select
//   o   out WIDTH  selected data
// ---------------------------------------------------------------------------
module mux2t1_4 #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] o
);

   assign o = sel ? b : a;

endmodule

// File: rtl/mux2t1_4_arb.sv
// ---------------------------------------------------------------------------
// mux2t1_4_arb
// Round-robin arbiter with bounded hold time that shares one mux2t1_4
// between source A and source B, and registers the selected word.
// Ports:
//   clk      in  1      system clock, rising edge
//   rst      in  1      synchronous active-high reset
//   req_a    in  1      source A requests the mux
//   req_b    in  1      source B requests the mux
//   a        in  WIDTH  source A data (selected when sel = 0)
//   b        in  WIDTH  source B data (selected when sel = 1)
//   gnt_a    out 1      A owns the mux this cycle
//   gnt_b    out 1      B owns the mux this cycle
//   sel      out 1      mux select, 1 only while B is granted
//   o        out WIDTH  registered mux output
//   o_valid  out 1      o holds data sampled under a grant
// ---------------------------------------------------------------------------
module mux2t1_4_arb
   import mux_arb_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             sel,
   output logic [WIDTH-1:0] o,
   output logic             o_valid
);

   // Counter value at which a waiting requester forces rotation.
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   arb_state_e        state_r;
   arb_state_e        state_s;
   logic              last_r;
   logic              last_s;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic [HOLD_W-1:0] hold_cnt_s;
   logic [WIDTH-1:0]  o_r;
   logic              o_valid_r;
   logic [WIDTH-1:0]  mux_o_s;
   logic              granted_s;

   // Moore outputs: decoded purely from the state register.
   assign gnt_a     = (state_r == GNT_A);
   assign gnt_b     = (state_r == GNT_B);
   assign sel       = (state_r == GNT_B);
   assign granted_s = gnt_a | gnt_b;
   assign o         = o_r;
   assign o_valid   = o_valid_r;

   mux2t1_4 #(
      .WIDTH (WIDTH)
   ) u_mux (
      .a   (a),
      .b   (b),
      .sel (sel),
      .o   (mux_o_s)
   );

   // Next-state, hold counter and last-served decisions.
   always_comb begin
      state_s    = state_r;
      last_s     = last_r;
      hold_cnt_s = hold_cnt_r;

      case (state_r)
         IDLE: begin
            if (req_a && req_b) begin
               // Tie goes to the side that was not served most recently.
               state_s = (last_r == SIDE_B) ? GNT_A : GNT_B;
            end else if (req_a) begin
               state_s = GNT_A;
            end else if (req_b) begin
               state_s = GNT_B;
            end else begin
               state_s = IDLE;
            end
         end
         GNT_A: begin
            if (!req_a) begin
               state_s = req_b ? GNT_B : IDLE;
            end else if (req_b && (hold_cnt_r == HOLD_LAST)) begin
               state_s = GNT_B;
            end else begin
               state_s = GNT_A;
            end
         end
         GNT_B: begin
            if (!req_b) begin
               state_s = req_a ? GNT_A : IDLE;
            end else if (req_a && (hold_cnt_r == HOLD_LAST)) begin
               state_s = GNT_A;
            end else begin
               state_s = GNT_B;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      // The counter saturates rather than wrapping, so an owner with no
      // competitor stays "due for rotation" until the other side shows up.
      if (state_s != state_r) begin
         hold_cnt_s = {HOLD_W{1'b0}};
      end else if ((state_r != IDLE) && (hold_cnt_r != HOLD_LAST)) begin
         hold_cnt_s = hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
      end else begin
         hold_cnt_s = hold_cnt_r;
      end

      if ((state_s == GNT_A) && (state_r != GNT_A)) begin
         last_s = SIDE_A;
      end else if ((state_s == GNT_B) && (state_r != GNT_B)) begin
         last_s = SIDE_B;
      end else begin
         last_s = last_r;
      end
   end

   // Arbiter state, last-served flag and hold counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         last_r     <= SIDE_B;
         hold_cnt_r <= {HOLD_W{1'b0}};
      end else begin
         state_r    <= state_s;
         last_r     <= last_s;
         hold_cnt_r <= hold_cnt_s;
      end
   end

   // Output data register: captures the mux word only under a grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_r       <= {WIDTH{1'b0}};
         o_valid_r <= 1'b0;
      end else begin
         if (granted_s) begin
            o_r <= mux_o_s;
         end else begin
            o_r <= o_r;
         end
         o_valid_r <= granted_s;
      end
   end

endmodule

// File: doc/mux2t1_4_arb.md
# mux2t1_4_arb

Two-requester arbiter that shares the 4-bit 2-to-1 data multiplexer (`mux2t1_4`) between source A and source B. It decides which source owns the mux each cycle, drives the mux select, and registers the selected word with a valid flag. Arbitration is round-robin with a bounded hold time, so neither source can starve the other. It sits directly in front of the mux and replaces the hand-driven `sel` used in bring-up.

## Interface
Parameters:
- `WIDTH`, 4: data width of `a`, `b` and `o`; must match the mux width.
- `MAX_HOLD`, 4: maximum consecutive grant cycles while the other side is waiting; legal range 1..15.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_a`  in  1  source A requests the mux.
- `req_b`  in  1  source B requests the mux.
- `a`  in  WIDTH  source A data; mux input selected when `sel`=0.
- `b`  in  WIDTH  source B data; mux input selected when `sel`=1.
- `gnt_a`  out  1  A owns the mux this cycle.
- `gnt_b`  out  1  B owns the mux this cycle.
- `sel`  out  1  mux select; 1 only while B is granted, else 0.
- `o`  out  WIDTH  registered mux output.
- `o_valid`  out  1  `o` holds data sampled under a grant.

## Operation
- FSM with states IDLE, GNT_A, GNT_B. `gnt_a`/`gnt_b`/`sel` decode from the state register only (Moore). The two grants are never both high.
- `last` flag records the most recently served side; reset value B, so A wins the first tie.
- IDLE: only `req_a` -> GNT_A. Only `req_b` -> GNT_B. Both -> the side opposite `last`. Neither -> stay.
- GNT_A (GNT_B symmetric):
  - `req_a` low and `req_b` high -> GNT_B.
  - `req_a` low and `req_b` low -> IDLE.
  - `req_a` high, `req_b` high and `hold_cnt` = MAX_HOLD-1 -> GNT_B (forced rotation).
  - Otherwise stay.
- `hold_cnt`: clears on every state change and on entry from IDLE. Otherwise it increments while granted, saturating at MAX_HOLD-1. If the waiting side is absent, the owner keeps the mux indefinitely with the counter saturated. A new request from the other side then rotates on the next edge.
- `last` updates to A/B on every entry into GNT_A/GNT_B.
- Datapath: each edge `o` <= (`sel` ? `b` : `a`) and `o_valid` <= (`gnt_a` | `gnt_b`). When not granted, `o` holds its previous value.
- Reset values: state IDLE, `last`=B, `hold_cnt`=0, `gnt_a`=`gnt_b`=`sel`=0, `o`=0, `o_valid`=0.

## Timing
- Request to grant: 1 cycle. `req_x` sampled high at edge N gives `gnt_x` high after edge N.
- Grant to data: 1 cycle. The word on `a`/`b` during a granted cycle appears on `o`, with `o_valid`=1, after the next edge.
- Switchover has no idle cycle: GNT_A -> GNT_B happens edge-to-edge, and `o_valid` stays high across it.
- Release: a requester dropping `req` at edge N loses its grant after edge N. `o_valid` falls one edge later, unless the other side is granted.
- Forced rotation: with both requesting continuously, each side holds exactly MAX_HOLD cycles, then alternates. For MAX_HOLD=1 the grant alternates every cycle.
- `rst` sampled high overrides everything, including mid-grant. All outputs take their reset values after that edge. Arbitration restarts from IDLE with A preferred.

## Structure
- Package `mux_arb_pkg`: state encoding constants (IDLE=2'd0, GNT_A=2'd1, GNT_B=2'd2) and the `DEFAULT_MAX_HOLD` value. `WIDTH` default is 4.
- Instantiate the existing `mux2t1_4` as the one sub-module for the select path. The arbiter adds only the output register, the FSM and `hold_cnt`.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `req_a`=`req_b`=1. Every output stays 0. After release, `gnt_a`=1 on the first edge.
- Single requester: `a`=4'b1010, `req_a`=1 only. `gnt_a`=1 and `sel`=0, then `o`=4'b1010 with `o_valid`=1 one cycle later. Dropping `req_a` clears `gnt_a` next edge and `o_valid` the edge after.
- Tie plus rotation: MAX_HOLD=4, `a`=4'b1010, `b`=4'b0001, both requesting from reset. Grant sequence is A×4, B×4, A×4. `o` alternates 1010/0001 in blocks of 4 with `o_valid` continuously 1.
- No starvation exemption: `req_a` only for 10 cycles, then `req_b` also raised. `gnt_b`=1 exactly one edge later (counter saturated).
- Direct handoff: in GNT_B, `req_b` falls while `req_a`=1. Next edge gives `gnt_a`=1, `sel`=0, with no IDLE cycle.
- Reset mid-operation: assert `rst` during GNT_B. Next edge gives `gnt_b`=0, `o`=0, `o_valid`=0. With both requesting after release, A is granted first.
